// File: rtl/rs75_serial_encoder.sv
`default_nettype none
// ============================================================================
// Module   : rs75_serial_encoder
// Purpose  : Symbol-serial systematic RS(7,5) encoder over GF(8); parallel
//            21-bit codeword out under a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module rs75_serial_encoder #(
    parameter int SYMBOL_WIDTH = 3,
    parameter int N            = 7,
    parameter int K            = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SYMBOL_WIDTH-1:0]     in_symbol,
    output logic                        cw_valid,
    input  logic                        cw_ready,
    output logic [N*SYMBOL_WIDTH-1:0]   codeword
);

    localparam int         c_MSG_W    = K * SYMBOL_WIDTH;
    localparam logic [2:0] c_LAST_CNT = 3'(K - 1);

    typedef enum logic [0:0] {
        c_st_load = 1'b0,
        c_st_hold = 1'b1
    } state_t;

    // Bit[2] is the coefficient of 1, bit[0] of alpha^2; alpha^3 = 1 + alpha.
    function automatic logic [2:0] gf_mul_alpha(input logic [2:0] s);
        gf_mul_alpha = {s[0], s[2] ^ s[0], s[1]};
    endfunction

    // g1 = alpha^4 = alpha + alpha^2
    function automatic logic [2:0] gf_mul_g1(input logic [2:0] s);
        gf_mul_g1 = gf_mul_alpha(s) ^ gf_mul_alpha(gf_mul_alpha(s));
    endfunction

    // g0 = alpha^3 = 1 + alpha
    function automatic logic [2:0] gf_mul_g0(input logic [2:0] s);
        gf_mul_g0 = s ^ gf_mul_alpha(s);
    endfunction

    state_t                      r_state;
    state_t                      w_state_next;
    logic [2:0]                  r_cnt;
    logic [SYMBOL_WIDTH-1:0]     r_r0;
    logic [SYMBOL_WIDTH-1:0]     r_r1;
    logic [c_MSG_W-1:0]          r_msg;
    logic [N*SYMBOL_WIDTH-1:0]   r_codeword;

    logic                        w_in_ready;
    logic                        w_cw_valid;
    logic                        w_accept;
    logic                        w_last;
    logic                        w_release;
    logic [SYMBOL_WIDTH-1:0]     w_fb;
    logic [SYMBOL_WIDTH-1:0]     w_r1_next;
    logic [SYMBOL_WIDTH-1:0]     w_r0_next;

    assign w_fb      = in_symbol ^ r_r1;
    assign w_r1_next = r_r0 ^ gf_mul_g1(w_fb);
    assign w_r0_next = gf_mul_g0(w_fb);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_load;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake qualifiers are gated by reset so nothing is seen to transfer
    // in a cycle whose edge will clear the block.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_cw_valid   = 1'b0;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            c_st_load: begin
                w_in_ready = reset;
                w_accept   = in_valid && reset;
                if (w_accept && (r_cnt == c_LAST_CNT)) begin
                    w_last       = 1'b1;
                    w_state_next = c_st_hold;
                end
            end
            c_st_hold: begin
                w_cw_valid = reset;
                if (cw_ready) begin
                    w_release    = 1'b1;
                    w_state_next = c_st_load;
                end
            end
            default: begin
                w_state_next = c_st_load;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt      <= 3'd0;
            r_r0       <= '0;
            r_r1       <= '0;
            r_msg      <= '0;
            r_codeword <= '0;
        end else if (w_accept) begin
            r_r1  <= w_r1_next;
            r_r0  <= w_r0_next;
            r_msg <= {r_msg[c_MSG_W-SYMBOL_WIDTH-1:0], in_symbol};
            if (w_last) begin
                r_cnt      <= 3'd0;
                r_codeword <= {r_msg[c_MSG_W-SYMBOL_WIDTH-1:0], in_symbol,
                               w_r1_next, w_r0_next};
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end else if (w_release) begin
            r_r0  <= '0;
            r_r1  <= '0;
            r_msg <= '0;
        end
    end

    assign in_ready = w_in_ready;
    assign cw_valid = w_cw_valid;
    assign codeword = r_codeword;

endmodule
`default_nettype wire

// File: tb/tb_rs75_serial_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs75_serial_encoder
// Purpose  : Directed self-checking bench for the RS(7,5) serial encoder.
// Revision : 1.0
// ============================================================================
module tb_rs75_serial_encoder;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_symbol;
    logic        cw_valid;
    logic        cw_ready;
    logic [20:0] codeword;

    int errors = 0;
    int checks = 0;

    rs75_serial_encoder #(
        .SYMBOL_WIDTH (3),
        .N            (7),
        .K            (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_symbol (in_symbol),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .codeword  (codeword)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Table-based GF(8) reference, bit[2] = coefficient of 1.
    function automatic logic [2:0] gexp(input int e);
        case (e % 7)
            0: gexp = 3'b100;
            1: gexp = 3'b010;
            2: gexp = 3'b001;
            3: gexp = 3'b110;
            4: gexp = 3'b011;
            5: gexp = 3'b111;
            default: gexp = 3'b101;
        endcase
    endfunction

    function automatic int glog(input logic [2:0] a);
        glog = 0;
        for (int k = 0; k < 7; k++) if (gexp(k) == a) glog = k;
    endfunction

    function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
        if (a == 3'b000 || b == 3'b000) gmul = 3'b000;
        else gmul = gexp(glog(a) + glog(b));
    endfunction

    function automatic logic [2:0] syndrome(input logic [20:0] cw, input int j);
        logic [2:0] acc;
        acc = 3'b000;
        for (int i = 6; i >= 0; i--) acc = gmul(acc, gexp(j)) ^ cw[3*i +: 3];
        syndrome = acc;
    endfunction

    // The unique parity pair that makes alpha and alpha^2 roots of c(x).
    function automatic logic [20:0] expected_cw(input logic [14:0] msg);
        logic [20:0] cw;
        expected_cw = '0;
        for (int p = 0; p < 64; p++) begin
            cw = {msg, 6'(p)};
            if (syndrome(cw, 1) == 3'b000 && syndrome(cw, 2) == 3'b000)
                expected_cw = cw;
        end
    endfunction

    task automatic send_sym(input logic [2:0] s);
        int t;
        t = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_symbol = s;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_msg(input logic [14:0] msg, input bit gaps, input bit hold_valid);
        int n;
        for (int i = 0; i < 5; i++) begin
            if (gaps) begin
                n = $urandom_range(0, 2);
                for (int g = 0; g < n; g++) begin
                    @(negedge clk);
                    in_valid  = 1'b0;
                    in_symbol = 3'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            send_sym(msg[14-3*i -: 3]);
        end
        if (!hold_valid) in_valid = 1'b0;
    endtask

    task automatic release_cw();
        @(negedge clk);
        cw_ready = 1'b1;
        @(posedge clk);
        #1;
        cw_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready_gated: got %b required 0", in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (cw_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_cw_valid: got %b required 0", cw_valid);
        end
        checks++;
        if (codeword !== 21'd0) begin
            errors++;
            $display("FAIL reset_codeword: got %h required 0", codeword);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_zero_latency();
        for (int i = 0; i < 4; i++) send_sym(3'b000);
        checks++;
        if (cw_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_early_valid: got %b required 0", cw_valid);
        end
        send_sym(3'b000);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cw_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_latency_valid: got %b required 1", cw_valid);
        end
        checks++;
        if (codeword !== 21'd0) begin
            errors++;
            $display("FAIL zero_codeword: got %h required 0", codeword);
        end
        release_cw();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || cw_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_release: in_ready=%b cw_valid=%b required 1/0", in_ready, cw_valid);
        end
    endtask

    task automatic test_directed();
        logic [14:0] msgs [3];
        logic [20:0] exps [3];
        msgs[0] = 15'b100_000_000_000_000;
        exps[0] = 21'b100_000_000_000_000_011_010;
        msgs[1] = 15'b000_000_000_000_100;
        exps[1] = 21'b000_000_000_000_100_011_110;
        msgs[2] = 15'b100_000_000_000_100;
        exps[2] = 21'b100_000_000_000_100_000_100;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            send_msg(msgs[i], 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if (cw_valid !== 1'b1 || codeword !== exps[i]) begin
                errors++;
                $display("FAIL directed_%0d: valid=%b cw=%b required 1 %b", i, cw_valid, codeword, exps[i]);
            end
            release_cw();
        end
    endtask

    task automatic test_hold_stall();
        logic [20:0] exp;
        exp = expected_cw(15'b101_011_110_001_111);
        send_msg(15'b101_011_110_001_111, 1'b1, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_symbol = 3'($urandom);
            checks++;
            if (in_ready !== 1'b0 || cw_valid !== 1'b1 || codeword !== exp) begin
                errors++;
                $display("FAIL hold_stall_%0d: in_ready=%b cw_valid=%b cw=%h required 0 1 %h",
                         c, in_ready, cw_valid, codeword, exp);
            end
        end
        in_valid = 1'b0;
        release_cw();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release_ready: got %b required 1", in_ready);
        end
        @(posedge clk);
        #1;
        exp = expected_cw(15'b010_110_001_100_011);
        send_msg(15'b010_110_001_100_011, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (cw_valid !== 1'b1 || codeword !== exp) begin
            errors++;
            $display("FAIL hold_restart: valid=%b cw=%h required 1 %h", cw_valid, codeword, exp);
        end
        release_cw();
    endtask

    task automatic test_cw_ready_in_load();
        logic [20:0] exp;
        exp = expected_cw(15'b111_111_111_111_111);
        cw_ready = 1'b1;
        send_msg(15'b111_111_111_111_111, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (cw_valid !== 1'b1 || codeword !== exp) begin
            errors++;
            $display("FAIL ready_in_load: valid=%b cw=%h required 1 %h", cw_valid, codeword, exp);
        end
        @(negedge clk);
        cw_ready = 1'b0;
        checks++;
        if (cw_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_in_load_xfer: valid=%b in_ready=%b required 0 1", cw_valid, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midway();
        logic [20:0] exp;
        for (int i = 0; i < 3; i++) send_sym(3'b110);
        in_valid = 1'b0;
        test_reset();
        @(posedge clk);
        #1;
        exp = expected_cw(15'b001_010_011_100_101);
        send_msg(15'b001_010_011_100_101, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (cw_valid !== 1'b1 || codeword !== exp) begin
            errors++;
            $display("FAIL reset_midway: valid=%b cw=%h required 1 %h", cw_valid, codeword, exp);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (cw_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_gate: got %b required 0", cw_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (cw_valid !== 1'b0 || codeword !== 21'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold_drop: valid=%b cw=%h in_ready=%b required 0 0 1",
                     cw_valid, codeword, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [14:0] msg;
        logic [20:0] exp;
        int          d;
        for (int n = 0; n < 100; n++) begin
            msg = 15'($urandom);
            exp = expected_cw(msg);
            send_msg(msg, 1'($urandom), 1'b0);
            @(negedge clk);
            checks++;
            if (cw_valid !== 1'b1 || codeword !== exp) begin
                errors++;
                $display("FAIL random_%0d: msg=%h valid=%b cw=%h required 1 %h", n, msg, cw_valid, codeword, exp);
            end
            d = $urandom_range(0, 3);
            repeat (d) @(negedge clk);
            release_cw();
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_symbol = 3'b000;
        cw_ready  = 1'b0;
        test_reset();
        @(posedge clk);
        #1;
        test_zero_latency();
        test_directed();
        test_hold_stall();
        test_cw_ready_in_load();
        test_reset_midway();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
